// File: rtl/nios_keys_pio.sv
// Avalon-MM input PIO: synchronized key/switch inputs, sticky edge capture
// with write-1-to-clear, and a maskable level interrupt.
module nios_keys_pio #(
    parameter int WIDTH       = 4,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic             read_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd2;
    localparam logic [1:0] ADDR_CAPTURE = 2'd3;
    localparam logic [2:0] ARM_MAX      = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [2:0]       arm_cnt;
    logic             armed;

    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] detect;
    logic [WIDTH-1:0] clear_mask;
    logic [31:0]      rd_mux;

    // Upper write-data bits have no destination when WIDTH < 32.
    logic             unused_wr_bits;
    assign unused_wr_bits = ^writedata;

    assign sync_q = sync_r[SYNC_STAGES-1];
    assign wr_en  = chipselect & ~write_n;
    assign rd_en  = chipselect & ~read_n;
    assign armed  = (arm_cnt == ARM_MAX);

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        detect = '0;
        case (EDGE_TYPE)
            0:       detect = sync_q & ~prev;
            1:       detect = ~sync_q & prev;
            default: detect = sync_q ^ prev;
        endcase
    end

    always_comb begin
        clear_mask = '0;
        if (wr_en && address == ADDR_CAPTURE)
            clear_mask = writedata[WIDTH-1:0];
    end

    // Reads see pre-write register values, so a same-cycle write is not visible.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = sync_q;
            ADDR_MASK:    rd_mux[WIDTH-1:0] = irq_mask;
            ADDR_CAPTURE: rd_mux[WIDTH-1:0] = edge_capture;
            default:      rd_mux = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_r[i] <= '0;
            prev         <= '0;
            edge_capture <= '0;
            irq_mask     <= '0;
            readdata     <= '0;
            arm_cnt      <= '0;
        end else begin
            sync_r[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_r[i] <= sync_r[i-1];
            prev <= sync_q;

            // Detection stays off until stale reset-time levels have left the chain.
            if (!armed)
                arm_cnt <= arm_cnt + 3'd1;

            // A fresh edge wins over a same-cycle clear.
            edge_capture <= (edge_capture & ~clear_mask) | (armed ? detect : '0);

            if (wr_en && address == ADDR_MASK)
                irq_mask <= writedata[WIDTH-1:0];

            if (rd_en)
                readdata <= rd_mux;
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_nios_keys_pio.sv
// Directed bench for nios_keys_pio: rising-edge instance (dut0) and any-edge
// instance (dut2) on a shared bus with separate chip selects.
module tb_nios_keys_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        cs0, cs2;
    logic        write_n, read_n;
    logic [31:0] writedata;
    logic [3:0]  in_port, in_port2;
    logic [31:0] rd0, rd2;
    logic        irq0, irq2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    nios_keys_pio #(.WIDTH(4), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs0),
        .write_n(write_n), .read_n(read_n), .writedata(writedata),
        .in_port(in_port), .readdata(rd0), .irq(irq0)
    );

    nios_keys_pio #(.WIDTH(4), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs2),
        .write_n(write_n), .read_n(read_n), .writedata(writedata),
        .in_port(in_port2), .readdata(rd2), .irq(irq2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input int unit, input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        cs0       = (unit == 0);
        cs2       = (unit == 2);
        tick();
        write_n   = 1'b1;
        cs0       = 1'b0;
        cs2       = 1'b0;
    endtask

    // Returns the register value as it stood when the read was issued.
    task automatic bus_read(input int unit, input logic [1:0] a, output logic [31:0] d);
        address = a;
        read_n  = 1'b0;
        cs0     = (unit == 0);
        cs2     = (unit == 2);
        tick();
        read_n  = 1'b1;
        cs0     = 1'b0;
        cs2     = 1'b0;
        d = (unit == 0) ? rd0 : rd2;
    endtask

    initial begin
        logic [31:0] v;

        reset_n   = 1'b0;
        address   = '0;
        cs0       = 1'b0;
        cs2       = 1'b0;
        write_n   = 1'b1;
        read_n    = 1'b1;
        writedata = '0;
        in_port   = 4'hF;
        in_port2  = 4'h0;

        // Reset with all inputs high, then release: no spurious capture.
        tick(2);
        check("reset_readdata", rd0, 32'h0);
        check("reset_irq", {31'b0, irq0}, 32'h0);
        check("reset_readdata_any", rd2, 32'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("arm_irq_low", {31'b0, irq0}, 32'h0);
        end
        bus_read(0, 2'd0, v); check("data_after_release", v, 32'h0000_000F);
        bus_read(0, 2'd3, v); check("capture_after_release", v, 32'h0);

        // Falling edge ignored; rising edge on bit 2 captured after 3 clocks.
        in_port = 4'hB;
        tick(3);
        bus_read(0, 2'd0, v); check("data_0xB", v, 32'h0000_000B);
        bus_write(0, 2'd2, 32'h4);
        bus_read(0, 2'd3, v); check("falling_not_captured", v, 32'h0);
        check("irq_idle", {31'b0, irq0}, 32'h0);
        in_port = 4'hF;
        tick(2);
        check("irq_before_latency", {31'b0, irq0}, 32'h0);
        tick();
        check("irq_at_latency", {31'b0, irq0}, 32'h1);
        bus_read(0, 2'd3, v); check("capture_bit2", v, 32'h0000_0004);
        bus_read(0, 2'd2, v); check("mask_readback", v, 32'h0000_0004);
        bus_read(0, 2'd1, v); check("reserved_reads_zero", v, 32'h0);
        bus_write(0, 2'd0, 32'h0);
        bus_read(0, 2'd0, v); check("data_write_ignored", v, 32'h0000_000F);

        // Read and write of the mask in one cycle: read sees the old value.
        address   = 2'd2;
        writedata = 32'hFFFF_FFF0;
        cs0       = 1'b1;
        write_n   = 1'b0;
        read_n    = 1'b0;
        tick();
        cs0       = 1'b0;
        write_n   = 1'b1;
        read_n    = 1'b1;
        check("rw_read_old", rd0, 32'h0000_0004);
        check("mask_clear_irq", {31'b0, irq0}, 32'h0);
        bus_read(0, 2'd2, v); check("mask_upper_ignored", v, 32'h0);
        bus_write(0, 2'd2, 32'h4);
        check("unmask_irq", {31'b0, irq0}, 32'h1);

        // Write-1-to-clear.
        bus_write(0, 2'd3, 32'h0);
        check("w1c_zero_irq", {31'b0, irq0}, 32'h1);
        bus_read(0, 2'd3, v); check("w1c_zero_capture", v, 32'h0000_0004);
        bus_write(0, 2'd3, 32'h4);
        check("w1c_irq", {31'b0, irq0}, 32'h0);
        bus_read(0, 2'd3, v); check("w1c_capture", v, 32'h0);

        // New edge lands on the same edge as the clear: the set wins.
        in_port = 4'hB;
        tick(3);
        in_port = 4'hF;
        tick(2);
        bus_write(0, 2'd3, 32'h4);
        check("collision_irq", {31'b0, irq0}, 32'h1);
        bus_read(0, 2'd3, v); check("collision_capture", v, 32'h0000_0004);
        bus_write(0, 2'd3, 32'h4);
        check("collision_cleared", {31'b0, irq0}, 32'h0);

        // Any-edge instance: both directions captured, mask gates irq.
        in_port2 = 4'h1;
        tick(3);
        bus_read(2, 2'd3, v); check("any_rise_capture", v, 32'h0000_0001);
        bus_write(2, 2'd3, 32'h1);
        bus_read(2, 2'd3, v); check("any_cleared", v, 32'h0);
        in_port2 = 4'h0;
        tick(3);
        bus_read(2, 2'd3, v); check("any_fall_capture", v, 32'h0000_0001);
        check("any_masked_irq", {31'b0, irq2}, 32'h0);
        bus_write(2, 2'd2, 32'h1);
        check("any_unmask_irq", {31'b0, irq2}, 32'h1);
        bus_read(2, 2'd2, v); check("any_mask_readback", v, 32'h0000_0001);

        // Mid-operation reset with everything captured and enabled.
        bus_write(0, 2'd2, 32'hF);
        in_port = 4'h0;
        tick(3);
        in_port = 4'hF;
        tick(3);
        bus_read(0, 2'd3, v); check("capture_all", v, 32'h0000_000F);
        check("irq_all", {31'b0, irq0}, 32'h1);
        reset_n = 1'b0;
        tick();
        check("midreset_readdata", rd0, 32'h0);
        check("midreset_irq", {31'b0, irq0}, 32'h0);
        reset_n = 1'b1;
        tick();
        in_port = 4'h0;
        tick(6);
        check("post_reset_irq", {31'b0, irq0}, 32'h0);
        bus_read(0, 2'd3, v); check("arm_window_no_capture", v, 32'h0);
        bus_read(0, 2'd2, v); check("post_reset_mask", v, 32'h0);
        bus_read(0, 2'd0, v); check("post_reset_data", v, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
